dmem_responder: RTL

//  Bus responder (target) for the core's load/store bus: accepts REQ/WE/HB/ADDR/WDATA

---
 rtl/dmem_responder_if.sv | 14 +
 rtl/dmem_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Load/store bus between the LSU (master) and the data-memory responder (slave).
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [1:0]  hb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        gnt;
    logic        err;

    modport master (output req, we, hb, addr, wdata, input rdata, gnt, err);
    modport slave  (input req, we, hb, addr, wdata, output rdata, gnt, err);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory bus responder: byte/half/word access on a word RAM, GNT after WAIT_STATES.
// Optional BUS_ERR_EN: flag misaligned, reserved-size and out-of-range accesses on o_ERR.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  hb_q, hb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ld_val;
    logic          acc_err;
    logic          commit;
    logic          mem_we;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        hb_d    = hb_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.req) begin
                    we_d    = bus.we;
                    hb_d    = bus.hb;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_d == 4'(WAIT_STATES)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The access uses the _d view of the captured fields so that with zero wait
    // states the request being captured is the one executed on the same edge.
    assign idx = addr_d[AW+1:2];

    always_comb begin
        be = 4'b1111;
        case (hb_d)
            2'b00:   be = 4'b0001 << addr_d[1:0];
            2'b01:   be = addr_d[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wlanes[8*gi +: 8] = (hb_d == 2'b00) ? wdata_d[7:0] :
                                   (hb_d == 2'b01) ? wdata_d[8*(gi%2) +: 8] :
                                                     wdata_d[8*gi +: 8];
    end

    assign rword = mem[idx];
    assign rbyte = 8'(rword >> {addr_d[1:0], 3'b000});
    assign rhalf = addr_d[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (hb_d)
            2'b00:   ld_val = {{24{rbyte[7]}}, rbyte};
            2'b01:   ld_val = {{16{rhalf[15]}}, rhalf};
            default: ld_val = rword;
        endcase
    end

`ifdef BUS_ERR_EN
    logic misalign;
    assign misalign = ((hb_d == 2'b01) && addr_d[0]) ||
                      ((hb_d == 2'b10) && (addr_d[1:0] != 2'b00));
    assign acc_err  = misalign || (hb_d == 2'b11) || (|addr_d[31:AW+2]);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:AW+2];
    assign acc_err        = 1'b0;
`endif

    always_comb begin
        commit  = (state_d == S_RESP) && (state_q != S_RESP);
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            rdata_d = (we_d || acc_err) ? 32'h0 : ld_val;
            err_d   = acc_err;
        end
    end

    // Gate on reset too: an access abandoned by reset must never reach the RAM.
    assign mem_we = commit && we_d && !acc_err && !i_rst;

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            hb_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            hb_q    <= hb_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.gnt   = (state_q == S_RESP);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule
